// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU MEM-stage request port and its data-memory responder.
package cpu_mem_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned STRB_W           = XLEN / 8;
  localparam int unsigned MEM_ERR_W        = 2;
  localparam int unsigned MEM_ERR_MISALIGN = 0;
  localparam int unsigned MEM_ERR_RANGE    = 1;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t;

  typedef struct packed {
    logic              write;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  // Error vector for a byte address against a byte-size limit; nonzero means reject.
  function automatic logic [MEM_ERR_W-1:0] mem_err(input logic [XLEN-1:0] addr,
                                                   input logic [XLEN-1:0] limit);
    logic [MEM_ERR_W-1:0] e;
    e                   = '0;
    e[MEM_ERR_MISALIGN] = (addr[1:0] != 2'b00);
    e[MEM_ERR_RANGE]    = (addr >= limit);
    return e;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write enables and a registered read.
module dmem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  // An enabled access with no lanes strobed is a read.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == '0) rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding load/store, fixed latency, valid/ready on both sides.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int unsigned CNT_W      = $clog2(LATENCY + 1);
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned BYTE_LIMIT = DEPTH_WORDS * 4;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              arr_en_c;
  logic [STRB_W-1:0] arr_we_c;
  logic [IDX_W-1:0]  arr_addr_c;
  logic [XLEN-1:0]   arr_rdata;
  logic              new_err_c;
  logic              held_err_c;

  assign new_err_c  = (mem_err(req_addr, XLEN'(BYTE_LIMIT)) != '0);
  assign held_err_c = (mem_err(req_q.addr, XLEN'(BYTE_LIMIT)) != '0);

  // Array read is issued one cycle before RESP entry so its registered output lands on that edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    arr_en_c     = 1'b0;
    arr_we_c     = '0;
    arr_addr_c   = req_q.addr[IDX_W+1:2];

    case (state_q)
      MEM_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = MEM_WAIT;
          if (LATENCY == 1 && !req_write && !new_err_c) begin
            arr_en_c   = 1'b1;
            arr_addr_c = req_addr[IDX_W+1:2];
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1) && !req_q.write && !held_err_c) arr_en_c = 1'b1;
        end else begin
          state_d      = MEM_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = held_err_c;
          resp_rdata_d = (req_q.write || held_err_c) ? '0 : arr_rdata;
          if (req_q.write && !held_err_c) begin
            arr_en_c = 1'b1;
            arr_we_c = req_q.wstrb;
          end
        end
      end
      MEM_RESP: begin
        if (resp_ready) begin
          state_d      = MEM_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = MEM_IDLE;
    endcase

    req_ready_d = (state_d == MEM_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= MEM_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Reset blocks the array so an uncommitted store is dropped.
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock (clock),
    .en    (arr_en_c && reset_n),
    .we    (arr_we_c),
    .addr  (arr_addr_c),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
